power_calc_scheduler: RTL and testbench

POWER_CALC_SCHEDULER -- requirements
Module: power_calc_scheduler

---
 rtl/power_calc_scheduler.sv | 166 ++++++++++++++++
 tb/tb_power_calc_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_calc_scheduler.sv
// rtl/power_calc_scheduler.sv - round-robin issue of per-channel power requests onto one pipelined datapath
module power_calc_scheduler #(
  parameter int NCH = 4,
  parameter int LAT = 24,
  parameter int W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*3*W-1:0] ch_v,
  input  logic [NCH*3*W-1:0] ch_i,
  output logic               dp_sta,
  output logic [W-1:0]       dp_va,
  output logic [W-1:0]       dp_vb,
  output logic [W-1:0]       dp_vc,
  output logic [W-1:0]       dp_ia,
  output logic [W-1:0]       dp_ib,
  output logic [W-1:0]       dp_ic,
  input  logic [W-1:0]       dp_p,
  input  logic               dp_done,
  output logic [NCH*W-1:0]   res_p,
  output logic [NCH-1:0]     res_valid,
  output logic [NCH-1:0]     ovr,
  output logic               err,
  input  logic               clear_err,
  output logic               busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   pend_q, pend_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3*W-1:0]   hold_v_q [NCH];
  logic [3*W-1:0]   hold_v_d [NCH];
  logic [3*W-1:0]   hold_i_q [NCH];
  logic [3*W-1:0]   hold_i_d [NCH];
  logic             dp_sta_q, dp_sta_d;
  logic [PW-1:0]    dp_ch_q, dp_ch_d;
  logic [3*W-1:0]   dp_v_q, dp_v_d, dp_i_q, dp_i_d;
  logic [LAT-1:0]   tag_v_q, tag_v_d;
  logic [PW-1:0]    tag_c_q [LAT];
  logic [PW-1:0]    tag_c_d [LAT];
  logic [NCH*W-1:0] res_p_q, res_p_d;
  logic [NCH-1:0]   res_valid_q, res_valid_d;
  logic [NCH-1:0]   ovr_q, ovr_d, ovr_set;
  logic             err_q, err_d, err_set;
  logic             busy_q, busy_d;
  logic             gnt_any;
  logic [PW-1:0]    gnt_ch, scan_idx;

  // First pending channel at or after ptr, wrapping.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_ch   = '0;
    scan_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % NCH);
      if (en && !gnt_any && pend_q[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = scan_idx;
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    ptr_d    = ptr_q;
    hold_v_d = hold_v_q;
    hold_i_d = hold_i_q;
    ovr_set  = '0;
    dp_sta_d = gnt_any;
    dp_ch_d  = dp_ch_q;
    dp_v_d   = dp_v_q;
    dp_i_d   = dp_i_q;
    if (gnt_any) begin
      dp_ch_d = gnt_ch;
      dp_v_d  = hold_v_q[gnt_ch];
      dp_i_d  = hold_i_q[gnt_ch];
      ptr_d   = PW'((int'(gnt_ch) + 1) % NCH);
    end
    // A request landing on its own grant cycle refills the hold slot being issued.
    for (int c = 0; c < NCH; c++) begin
      if (gnt_any && gnt_ch == PW'(c)) pend_d[c] = 1'b0;
      if (req[c]) begin
        if (!pend_q[c] || (gnt_any && gnt_ch == PW'(c))) begin
          pend_d[c]   = 1'b1;
          hold_v_d[c] = ch_v[c*3*W +: 3*W];
          hold_i_d[c] = ch_i[c*3*W +: 3*W];
        end else begin
          ovr_set[c] = 1'b1;
        end
      end
    end

    tag_v_d    = {tag_v_q[LAT-2:0], dp_sta_q};
    tag_c_d[0] = dp_ch_q;
    for (int k = 1; k < LAT; k++) tag_c_d[k] = tag_c_q[k-1];

    res_p_d     = res_p_q;
    res_valid_d = '0;
    err_set     = dp_done != tag_v_q[LAT-1];
    for (int c = 0; c < NCH; c++) begin
      if (dp_done && tag_v_q[LAT-1] && tag_c_q[LAT-1] == PW'(c)) begin
        res_p_d[c*W +: W] = dp_p;
        res_valid_d[c]    = 1'b1;
      end
    end

    ovr_d  = (clear_err ? '0 : ovr_q) | ovr_set;
    err_d  = (err_q && !clear_err) || err_set;
    busy_d = (|pend_d) || dp_sta_d || (|tag_v_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      ptr_q       <= '0;
      dp_sta_q    <= 1'b0;
      dp_ch_q     <= '0;
      dp_v_q      <= '0;
      dp_i_q      <= '0;
      tag_v_q     <= '0;
      res_p_q     <= '0;
      res_valid_q <= '0;
      ovr_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        hold_v_q[c] <= '0;
        hold_i_q[c] <= '0;
      end
      for (int k = 0; k < LAT; k++) tag_c_q[k] <= '0;
    end else begin
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      dp_sta_q    <= dp_sta_d;
      dp_ch_q     <= dp_ch_d;
      dp_v_q      <= dp_v_d;
      dp_i_q      <= dp_i_d;
      tag_v_q     <= tag_v_d;
      res_p_q     <= res_p_d;
      res_valid_q <= res_valid_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      hold_v_q    <= hold_v_d;
      hold_i_q    <= hold_i_d;
      tag_c_q     <= tag_c_d;
    end
  end

  assign dp_sta    = dp_sta_q;
  assign dp_va     = dp_v_q[0   +: W];
  assign dp_vb     = dp_v_q[W   +: W];
  assign dp_vc     = dp_v_q[2*W +: W];
  assign dp_ia     = dp_i_q[0   +: W];
  assign dp_ib     = dp_i_q[W   +: W];
  assign dp_ic     = dp_i_q[2*W +: W];
  assign res_p     = res_p_q;
  assign res_valid = res_valid_q;
  assign ovr       = ovr_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_power_calc_scheduler.sv
// tb/tb_power_calc_scheduler.sv - directed scoreboard bench for power_calc_scheduler
module tb_power_calc_scheduler;
  localparam int NCH = 4;
  localparam int LAT = 24;
  localparam int W   = 32;

  logic clk = 1'b0;
  logic rst, en, clear_err, force_done;
  logic [NCH-1:0] req;
  logic [NCH*3*W-1:0] ch_v, ch_i;
  logic dp_sta, dp_done, err, busy;
  logic [W-1:0] dp_va, dp_vb, dp_vc, dp_ia, dp_ib, dp_ic, dp_p;
  logic [NCH*W-1:0] res_p;
  logic [NCH-1:0] res_valid, ovr;
  logic md_done;
  logic [W-1:0] md_p;
  logic mdv [LAT+1];
  logic [W-1:0] mdp [LAT+1];

  typedef struct { int ch; logic [W-1:0] p; } exp_t;
  exp_t sb[$];
  int g[$];
  int total = 0;
  int bad = 0;
  int nre, ch;
  logic [W-1:0] e_a, va_a;

  assign dp_done = md_done | force_done;
  assign dp_p    = force_done ? 32'hDEAD_BEEF : md_p;

  power_calc_scheduler #(.NCH(NCH), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ch_v(ch_v), .ch_i(ch_i),
    .dp_sta(dp_sta), .dp_va(dp_va), .dp_vb(dp_vb), .dp_vc(dp_vc),
    .dp_ia(dp_ia), .dp_ib(dp_ib), .dp_ic(dp_ic), .dp_p(dp_p), .dp_done(dp_done),
    .res_p(res_p), .res_valid(res_valid), .ovr(ovr), .err(err),
    .clear_err(clear_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pmodel(input logic [W-1:0] va, vb, vc, ia, ib, ic);
    return (va & ia) + ((vb & ib) << 1) + ((vc & ic) << 2) + (va - ia);
  endfunction

  function automatic logic [W-1:0] vsl(input logic [NCH*3*W-1:0] bus, input int c, input int p);
    return bus[(3*c+p)*W +: W];
  endfunction

  function automatic logic [W-1:0] exp_for(input int c);
    return pmodel(vsl(ch_v, c, 0), vsl(ch_v, c, 1), vsl(ch_v, c, 2),
                  vsl(ch_i, c, 0), vsl(ch_i, c, 1), vsl(ch_i, c, 2));
  endfunction

  function automatic int chan_of(input logic [W-1:0] va);
    for (int c = 0; c < NCH; c++) if (vsl(ch_v, c, 0) == va) return c;
    return 99;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c);
    exp_t e;
    e.ch = c;
    e.p  = exp_for(c);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && sb.size() != 0; k++) tick(1);
    chk("drain", sb.size(), 0);
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] va, vb, vc, ia, ib, ic);
    ch_v[(3*c+0)*W +: W] = va;
    ch_v[(3*c+1)*W +: W] = vb;
    ch_v[(3*c+2)*W +: W] = vc;
    ch_i[(3*c+0)*W +: W] = ia;
    ch_i[(3*c+1)*W +: W] = ib;
    ch_i[(3*c+2)*W +: W] = ic;
  endtask

  // Fixed-latency datapath stand-in: returns pmodel of the issued operands LAT cycles after dp_sta.
  initial begin
    for (int k = 0; k <= LAT; k++) begin
      mdv[k] = 1'b0;
      mdp[k] = '0;
    end
    md_done = 1'b0;
    md_p    = '0;
    forever begin
      @(negedge clk);
      for (int k = LAT; k > 0; k--) begin
        mdv[k] = mdv[k-1];
        mdp[k] = mdp[k-1];
      end
      mdv[0]  = dp_sta;
      mdp[0]  = pmodel(dp_va, dp_vb, dp_vc, dp_ia, dp_ib, dp_ic);
      md_done = mdv[LAT];
      md_p    = mdp[LAT];
    end
  end

  // Result monitor: every res_valid pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int c = 0; c < NCH; c++) begin
          if (res_valid[c]) begin
            if (sb.size() == 0) begin
              chk("res_unexp", res_valid, '0);
            end else begin
              e = sb.pop_front();
              chk("res_ch", c, e.ch);
              chk("res_p", res_p[c*W +: W], e.p);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; req = '0; ch_v = '0; ch_i = '0;
    clear_err = 1'b0; force_done = 1'b0;
    tick(2);
    chk("rst_sta", dp_sta, 0);
    chk("rst_va", dp_va, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", res_p, 0);
    rst = 1'b1;
    tick(2);

    // all four channels at once, ptr=0
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < 3; p++) begin
        ch_v[(3*c+p)*W +: W] = 32'h4000_0000 | (32'(c) << 16) | (32'(p) << 8) | 32'd1;
        ch_i[(3*c+p)*W +: W] = 32'h3000_0000 | (32'(c) << 16) | (32'(p) << 8) | 32'd2;
      end
    req = '1;
    for (int c = 0; c < NCH; c++) push(c);
    tick(1);
    req = '0;
    chk("q4_sta_t1", dp_sta, 0);
    chk("q4_busy", busy, 1);
    tick(1);
    for (int c = 0; c < NCH; c++) begin
      chk("q4_sta", dp_sta, 1);
      chk("q4_va", dp_va, vsl(ch_v, c, 0));
      chk("q4_ic", dp_ic, vsl(ch_i, c, 2));
      tick(1);
    end
    chk("q4_sta_end", dp_sta, 0);
    drain();

    // fairness: 0 and 3 re-request as soon as each grant shows up
    req = 4'b1001;
    push(0);
    push(3);
    nre = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      req = '0;
      if (dp_sta) begin
        ch = chan_of(dp_va);
        g.push_back(ch);
        if (nre < 6 && ch < NCH) begin
          req[ch] = 1'b1;
          push(ch);
          nre++;
        end
      end
    end
    req = '0;
    chk("fair_n", g.size(), 8);
    for (int k = 0; k < g.size(); k++) chk("fair_g", g[k], (k % 2 == 0) ? 0 : 3);
    chk("fair_ovr", ovr, 0);
    drain();

    // single request on channel 2, exact latency
    set_ch(2, 32'h3F80_0000, 0, 0, 32'h3F80_0000, 0, 0);
    req = 4'b0100;
    push(2);
    tick(1);
    req = '0;
    chk("s_busy", busy, 1);
    chk("s_sta_t1", dp_sta, 0);
    tick(1);
    chk("s_sta", dp_sta, 1);
    chk("s_va", dp_va, 32'h3F80_0000);
    chk("s_ia", dp_ia, 32'h3F80_0000);
    chk("s_vb", dp_vb, 0);
    tick(1);
    chk("s_hold_va", dp_va, 32'h3F80_0000);
    tick(23);
    chk("s_rv_early", res_valid, 0);
    tick(1);
    chk("s_rv", res_valid, 4'b0100);
    chk("s_resp", res_p[2*W +: W], 32'h3F80_0000);
    tick(1);
    chk("s_busy_end", busy, 0);
    chk("s_err", err, 0);

    // overrun while issue disabled
    en = 1'b0;
    set_ch(1, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003);
    e_a  = exp_for(1);
    va_a = 32'h1111_0001;
    req = 4'b0010;
    tick(1);
    set_ch(1, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003);
    req = 4'b0010;
    tick(1);
    req = '0;
    chk("ovr_set", ovr, 4'b0010);
    chk("ovr_nosta", dp_sta, 0);
    tick(1);
    chk("ovr_hold_sta", dp_sta, 0);
    chk("ovr_busy", busy, 1);
    sb.push_back('{1, e_a});
    en = 1'b1;
    tick(1);
    chk("ovr_sta", dp_sta, 1);
    chk("ovr_va", dp_va, va_a);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("ovr_clr", ovr, 0);
    drain();
    chk("ovr_err", err, 0);

    // spurious done with empty tag pipe
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    chk("sp_err", err, 1);
    chk("sp_rv", res_valid, 0);
    tick(1);
    chk("sp_sticky", err, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("sp_clr", err, 0);

    // reset while a request is in flight
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(2);
    chk("mr_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mr_va", dp_va, 0);
    chk("mr_resp", res_p, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_ovr", ovr, 0);
    chk("mr_rv", res_valid, 0);
    sb.delete();
    tick(1);
    rst = 1'b1;
    tick(23);
    chk("mr_late_err", err, 1);
    chk("mr_late_rv", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
